assoc_cmd_sequencer: RTL and testbench
======================================

// Module: assoc_cmd_sequencer
// PURPOSE
//  Upstream command stage for the associative buffer (KEY/DATA/CTRL interface, 1-cycle registered result).
//  Accepts keyed commands over a valid/ready handshake and queues them in a small FIFO.
//  Issues each command to the buffer for exactly one cycle, then captures the buffer's valid/data result.
//  Returns one response per command on a valid/ready port; also provides a clear-all key sweep.
// PARAMETERS
//  KEY_WIDTH   5  key width; sweep covers keys 0 .. 2**KEY_WIDTH-1
//  DATA_WIDTH  8  data width
//  CTRL_WIDTH  2  op width (0 NONE, 1 CLR, 2 LOAD, 3 INCR)
//  FIFO_DEPTH  4  command FIFO entries, power of two, >= 2
// PORTS
//  clk           in   1              clock, rising edge
//  rst           in   1              asynchronous, active-low reset
//  cmd_valid     in   1              command present
//  cmd_ready     out  1              command accepted when cmd_valid & cmd_ready
//  cmd_op        in   CTRL_WIDTH     operation applied to the keyed entry
//  cmd_key       in   KEY_WIDTH      entry key
//  cmd_data      in   DATA_WIDTH     operand for LOAD
//  sweep_start   in   1              pulse: request clear-all sweep
//  sweep_busy    out  1              sweep in progress
//  buf_ctrl      out  CTRL_WIDTH     to buffer ctrl
//  buf_key       out  KEY_WIDTH      to buffer key
//  buf_data      out  DATA_WIDTH     to buffer data_input
//  buf_data_out  in   DATA_WIDTH     from buffer data_output (registered)
//  buf_valid     in   1              from buffer valid (registered): key was present
//  rsp_valid     out  1              response present
//  rsp_ready     in   1              response consumed when rsp_valid & rsp_ready
//  rsp_hit       out  1              captured buf_valid
//  rsp_data      out  DATA_WIDTH     captured buf_data_out
//  rsp_key       out  KEY_WIDTH      key of the command this response belongs to
//  fifo_count    out  log2(FIFO_DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//  Reset (rst low, immediate): FIFO empty, fifo_count=0, FSM IDLE, all outputs 0 except cmd_ready=1.
//  FIFO: push on cmd_valid&cmd_ready; cmd_ready = !full & !sweep_busy & !sweep_pending.
//   Full: cmd_ready=0. A simultaneous push and pop leaves the count unchanged. Pointers wrap mod FIFO_DEPTH.
//  FSM states:
//   IDLE: if sweep_pending & FIFO empty -> SWEEP; else if FIFO non-empty -> ISSUE.
//   ISSUE (1 cycle): buf_ctrl/key/data = FIFO head; pop head; -> WAIT.
//   WAIT (1 cycle): buffer result is now valid; rsp_hit<=buf_valid, rsp_data<=buf_data_out, rsp_key<=issued key; -> RESP.
//   RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake -> IDLE.
//   SWEEP: sweep_busy=1; buf_ctrl=CLR, buf_key=counter, counter 0..2**KEY_WIDTH-1, one per cycle.
//    After the last key -> IDLE. No responses are generated by a sweep.
//  Outside ISSUE/SWEEP: buf_ctrl=NONE; buf_key/buf_data hold the last driven values (0 after reset).
//  Latency: accept -> ISSUE at earliest the next cycle; ISSUE -> rsp_valid 2 cycles later.
//   Minimum 4 cycles per command when rsp_ready is held high.
//  Only one command is in flight; a new ISSUE never starts before the previous response handshake completes.
//  sweep_start: sets sweep_pending (sticky, cleared on entering SWEEP).
//   Queued commands drain first; new cmds blocked while pending or busy.
//   sweep_start during SWEEP is ignored.
//  Reset mid-operation: FIFO contents, pending response and sweep are discarded; no partial response.
// TESTING
//  1. Reset, push {LOAD,key=3,data=0x5A}, rsp_ready=1.
//     -> buf_ctrl=2/key=3/data=0x5A for 1 cycle; 2 cycles later rsp_valid=1, rsp_key=3.
//  2. Push {NONE,key=3} after test 1 -> rsp_hit=1, rsp_data=0x5A.
//     Push {NONE,key=9} on a fresh buffer -> rsp_hit=0.
//  3. Push 4 cmds with rsp_ready=0.
//     -> fifo_count reaches 3 then stays (one issued and held in RESP); 4th cmd waits, cmd_ready=0 when full.
//     Release rsp_ready -> 4 responses in order.
//  4. 2 cmds queued, pulse sweep_start -> both responses complete first.
//     Then 32 consecutive cycles buf_ctrl=1, buf_key 0..31; cmd_ready=0 throughout.
//  5. Assert rst low during WAIT -> rsp_valid, fifo_count, sweep_busy, buf_ctrl all 0 immediately.
//     After release, cmd_ready=1.
//  6. Push and pop in the same cycle with FIFO at 2 -> fifo_count stays 2.
//     Pointer wrap after 9 commands keeps order.

Source files
------------

// File: rtl/assoc_cmd_sequencer.sv
// assoc_cmd_sequencer
// Command stage in front of the associative buffer. Keyed commands are queued in
// a small FIFO. Each one goes to the buffer for a single cycle. The buffer's
// registered result is then captured and returned as one response per command.
// A clear-all sweep walks every key with CLR once the queued work has drained.
module assoc_cmd_sequencer #(
  parameter int KEY_WIDTH  = 5,
  parameter int DATA_WIDTH = 8,
  parameter int CTRL_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [CTRL_WIDTH-1:0]         cmd_op,
  input  logic [KEY_WIDTH-1:0]          cmd_key,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  input  logic                          sweep_start,
  output logic                          sweep_busy,
  output logic [CTRL_WIDTH-1:0]         buf_ctrl,
  output logic [KEY_WIDTH-1:0]          buf_key,
  output logic [DATA_WIDTH-1:0]         buf_data,
  input  logic [DATA_WIDTH-1:0]         buf_data_out,
  input  logic                          buf_valid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_hit,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [KEY_WIDTH-1:0]          rsp_key,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CTRL_WIDTH-1:0] OP_NONE    = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_CLR     = CTRL_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_SWEEP
  } state_t;

  state_t state;
  state_t state_next;

  logic [CTRL_WIDTH-1:0] fifo_op   [FIFO_DEPTH];
  logic [KEY_WIDTH-1:0]  fifo_key  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  logic                  sweep_pending;
  logic [KEY_WIDTH-1:0]  sweep_cnt;
  logic                  sweep_last;

  logic [KEY_WIDTH-1:0]  key_hold;
  logic [DATA_WIDTH-1:0] data_hold;

  logic [CTRL_WIDTH-1:0] head_op;
  logic [KEY_WIDTH-1:0]  head_key;
  logic [DATA_WIDTH-1:0] head_data;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full && !sweep_busy && !sweep_pending;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == ST_ISSUE);
  assign fifo_count = count;
  assign sweep_last = (sweep_cnt == {KEY_WIDTH{1'b1}});

  assign head_op    = fifo_op[rd_ptr];
  assign head_key   = fifo_key[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Queue storage: written at the tail on every accepted command; no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= cmd_op;
      fifo_key[wr_ptr]  <= cmd_key;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky sweep request, dropped when the sweep actually starts; requests during a sweep are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_pending <= 1'b0;
    end else if (state == ST_IDLE && state_next == ST_SWEEP) begin
      sweep_pending <= 1'b0;
    end else if (sweep_start && state != ST_SWEEP) begin
      sweep_pending <= 1'b1;
    end
  end

  // Sweep key counter: advances once per sweep cycle and rolls back to zero after the last key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_cnt <= '0;
    end else if (state == ST_SWEEP) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one command in flight at a time; sweep only once the queue has drained
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (sweep_pending && fifo_empty) begin
          state_next = ST_SWEEP;
        end else if (!fifo_empty) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      ST_SWEEP: begin
        if (sweep_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: drive the buffer in ISSUE/SWEEP, otherwise NONE with key/data held
  always_comb begin
    buf_ctrl   = OP_NONE;
    buf_key    = key_hold;
    buf_data   = data_hold;
    sweep_busy = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_ISSUE: begin
        buf_ctrl = head_op;
        buf_key  = head_key;
        buf_data = head_data;
      end
      ST_SWEEP: begin
        buf_ctrl   = OP_CLR;
        buf_key    = sweep_cnt;
        sweep_busy = 1'b1;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Remember the last key/data driven to the buffer so they hold between commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_hold  <= '0;
      data_hold <= '0;
    end else begin
      key_hold  <= buf_key;
      data_hold <= buf_data;
    end
  end

  // Capture the buffer result in WAIT; key_hold still carries the issued key then
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_hit  <= 1'b0;
      rsp_data <= '0;
      rsp_key  <= '0;
    end else if (state == ST_WAIT) begin
      rsp_hit  <= buf_valid;
      rsp_data <= buf_data_out;
      rsp_key  <= key_hold;
    end
  end

endmodule

// File: tb/tb_assoc_cmd_sequencer.sv
// tb_assoc_cmd_sequencer
// Directed bench for assoc_cmd_sequencer. It includes a small behavioural model
// of the associative buffer with a 1-cycle registered result. Responses are
// collected at each handshake and compared against hand-computed values.
module tb_assoc_cmd_sequencer;

  localparam int KW = 5;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_op;
  logic [KW-1:0] cmd_key;
  logic [DW-1:0] cmd_data;
  logic          sweep_start;
  logic          sweep_busy;
  logic [CW-1:0] buf_ctrl;
  logic [KW-1:0] buf_key;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] buf_data_out = '0;
  logic          buf_valid = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [DW-1:0] rsp_data;
  logic [KW-1:0] rsp_key;
  logic [$clog2(FD):0] fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          hit;
    logic [DW-1:0] data;
    logic [KW-1:0] key;
  } rsp_t;

  rsp_t rspQ[$];

  // Associative buffer model state
  logic [DW-1:0]      mem [32];
  logic [(1<<KW)-1:0] vld = '0;

  always #5 clk = ~clk;

  assoc_cmd_sequencer #(
    .KEY_WIDTH (KW),
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_key     (cmd_key),
    .cmd_data    (cmd_data),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .buf_ctrl    (buf_ctrl),
    .buf_key     (buf_key),
    .buf_data    (buf_data),
    .buf_data_out(buf_data_out),
    .buf_valid   (buf_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_hit     (rsp_hit),
    .rsp_data    (rsp_data),
    .rsp_key     (rsp_key),
    .fifo_count  (fifo_count)
  );

  // Buffer model: apply the op and present a registered valid/data result one cycle later
  always @(posedge clk) begin
    case (buf_ctrl)
      2'd1: begin
        vld[buf_key] <= 1'b0;
        buf_valid    <= 1'b0;
        buf_data_out <= '0;
      end
      2'd2: begin
        vld[buf_key] <= 1'b1;
        mem[buf_key] <= buf_data;
        buf_valid    <= 1'b1;
        buf_data_out <= buf_data;
      end
      2'd3: begin
        if (vld[buf_key]) begin
          mem[buf_key] <= mem[buf_key] + 8'd1;
          buf_data_out <= mem[buf_key] + 8'd1;
        end else begin
          buf_data_out <= '0;
        end
        buf_valid <= vld[buf_key];
      end
      default: begin
        buf_valid    <= vld[buf_key];
        buf_data_out <= vld[buf_key] ? mem[buf_key] : '0;
      end
    endcase
  end

  // Response collector: record every completed response handshake in order
  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rspQ.push_back({rsp_hit, rsp_data, rsp_key});
    end
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one command from a negedge and hold it until it is accepted
  task automatic applyStimulus(input logic [CW-1:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data);
    int n;
    cmd_op    = op;
    cmd_key   = key;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("push_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until n responses have been collected in total
  task automatic waitRsp(input int n);
    int c;
    c = 0;
    while (rspQ.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("rsp_count", 32'(rspQ.size()), 32'(n));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int base;
    int n;
    rsp_t r;

    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_key     = '0;
    cmd_data    = '0;
    sweep_start = 1'b0;
    rsp_ready   = 1'b1;
    idleCycles(3);

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    checkOutput("rst_buf_ctrl",   32'(buf_ctrl),   32'd0);
    checkOutput("rst_buf_key",    32'(buf_key),    32'd0);
    checkOutput("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    rst = 1'b1;
    idleCycles(1);

    $display("[TB] single LOAD and issue/response timing");
    applyStimulus(2'd2, 5'd3, 8'h5A);
    n = 0;
    while (buf_ctrl == 2'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t1_issue_ctrl", 32'(buf_ctrl), 32'd2);
    checkOutput("t1_issue_key",  32'(buf_key),  32'd3);
    checkOutput("t1_issue_data", 32'(buf_data), 32'h5A);
    checkOutput("t1_issue_rspv", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_wait_ctrl",  32'(buf_ctrl), 32'd0);
    checkOutput("t1_wait_hold",  32'(buf_key),  32'd3);
    checkOutput("t1_wait_rspv",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_rsp_valid",  32'(rsp_valid), 32'd1);
    checkOutput("t1_rsp_key",    32'(rsp_key),   32'd3);
    checkOutput("t1_rsp_hit",    32'(rsp_hit),   32'd1);
    checkOutput("t1_rsp_data",   32'(rsp_data),  32'h5A);
    waitRsp(1);

    $display("[TB] lookup hit and miss");
    applyStimulus(2'd0, 5'd3, 8'h00);
    waitRsp(2);
    r = rspQ[1];
    checkOutput("t2_hit",      32'(r.hit),  32'd1);
    checkOutput("t2_hit_data", 32'(r.data), 32'h5A);
    checkOutput("t2_hit_key",  32'(r.key),  32'd3);
    applyStimulus(2'd0, 5'd9, 8'h00);
    waitRsp(3);
    r = rspQ[2];
    checkOutput("t2_miss",     32'(r.hit),  32'd0);
    checkOutput("t2_miss_key", 32'(r.key),  32'd9);

    $display("[TB] back-pressure and full FIFO");
    idleCycles(2);
    base = rspQ.size();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(2'd2, 5'(10 + i), 8'(8'h30 + i));
    checkOutput("t3_count3",     32'(fifo_count), 32'd3);
    checkOutput("t3_ready3",     32'(cmd_ready),  32'd1);
    idleCycles(3);
    checkOutput("t3_count3_hold", 32'(fifo_count), 32'd3);
    checkOutput("t3_rsp_held",   32'(rsp_valid),  32'd1);
    checkOutput("t3_rsp_key",    32'(rsp_key),    32'd10);
    applyStimulus(2'd2, 5'd14, 8'h34);
    checkOutput("t3_count_full", 32'(fifo_count), 32'd4);
    checkOutput("t3_ready_full", 32'(cmd_ready),  32'd0);
    cmd_op    = 2'd2;
    cmd_key   = 5'd15;
    cmd_data  = 8'h35;
    cmd_valid = 1'b1;
    idleCycles(3);
    checkOutput("t3_blocked_ready", 32'(cmd_ready),  32'd0);
    checkOutput("t3_blocked_count", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t3_ready_again", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    waitRsp(base + 6);
    for (int i = 0; i < 6; i++) begin
      r = rspQ[base + i];
      checkOutput("t3_order_key",  32'(r.key),  32'(10 + i));
      checkOutput("t3_order_data", 32'(r.data), 32'(8'h30 + i));
    end

    $display("[TB] simultaneous push/pop and pointer wrap");
    idleCycles(2);
    base = rspQ.size();
    applyStimulus(2'd2, 5'd1, 8'h11);
    applyStimulus(2'd2, 5'd2, 8'h22);
    checkOutput("t6_pre_count", 32'(fifo_count), 32'd2);
    checkOutput("t6_in_issue",  32'(buf_ctrl),   32'd2);
    checkOutput("t6_issue_key", 32'(buf_key),    32'd1);
    applyStimulus(2'd2, 5'd4, 8'h44);
    checkOutput("t6_pushpop_count", 32'(fifo_count), 32'd2);
    for (int i = 0; i < 9; i++) applyStimulus(2'd2, 5'(20 + i), 8'(8'h60 + i));
    waitRsp(base + 12);
    checkOutput("t6_key0", 32'(rspQ[base].key),     32'd1);
    checkOutput("t6_key1", 32'(rspQ[base + 1].key), 32'd2);
    checkOutput("t6_key2", 32'(rspQ[base + 2].key), 32'd4);
    for (int i = 0; i < 9; i++) begin
      r = rspQ[base + 3 + i];
      checkOutput("t6_wrap_key",  32'(r.key),  32'(20 + i));
      checkOutput("t6_wrap_data", 32'(r.data), 32'(8'h60 + i));
    end

    $display("[TB] clear-all sweep after queued commands");
    idleCycles(2);
    base = rspQ.size();
    applyStimulus(2'd2, 5'd5, 8'h55);
    applyStimulus(2'd2, 5'd6, 8'h66);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    checkOutput("t4_pending_blocks", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!sweep_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_sweep_started", 32'(sweep_busy), 32'd1);
    checkOutput("t4_rsp_first",     32'(rspQ.size()), 32'(base + 2));
    for (int i = 0; i < 32; i++) begin
      checkOutput("t4_sweep_ctrl",  32'(buf_ctrl),   32'd1);
      checkOutput("t4_sweep_key",   32'(buf_key),    32'(i));
      checkOutput("t4_sweep_ready", 32'(cmd_ready),  32'd0);
      checkOutput("t4_sweep_rspv",  32'(rsp_valid),  32'd0);
      sweep_start = (i == 5);
      @(negedge clk);
    end
    sweep_start = 1'b0;
    checkOutput("t4_done_busy",  32'(sweep_busy), 32'd0);
    checkOutput("t4_done_ctrl",  32'(buf_ctrl),   32'd0);
    checkOutput("t4_done_hold",  32'(buf_key),    32'd31);
    checkOutput("t4_done_ready", 32'(cmd_ready),  32'd1);
    idleCycles(3);
    checkOutput("t4_start_ignored", 32'(sweep_busy), 32'd0);
    checkOutput("t4_no_sweep_rsp",  32'(rspQ.size()), 32'(base + 2));
    applyStimulus(2'd0, 5'd3, 8'h00);
    waitRsp(base + 3);
    checkOutput("t4_cleared_hit", 32'(rspQ[base + 2].hit), 32'd0);
    checkOutput("t4_cleared_key", 32'(rspQ[base + 2].key), 32'd3);

    $display("[TB] reset in the middle of a command");
    idleCycles(2);
    rsp_ready = 1'b0;
    applyStimulus(2'd2, 5'd7, 8'h77);
    applyStimulus(2'd2, 5'd8, 8'h88);
    @(negedge clk);
    checkOutput("t5_pre_count", 32'(fifo_count), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t5_rsp_valid",  32'(rsp_valid),  32'd0);
    checkOutput("t5_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("t5_sweep_busy", 32'(sweep_busy), 32'd0);
    checkOutput("t5_buf_ctrl",   32'(buf_ctrl),   32'd0);
    checkOutput("t5_rsp_key",    32'(rsp_key),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    base = rspQ.size();
    idleCycles(6);
    checkOutput("t5_after_ready", 32'(cmd_ready),  32'd1);
    checkOutput("t5_after_rspv",  32'(rsp_valid),  32'd0);
    checkOutput("t5_no_partial",  32'(rspQ.size()), 32'(base));
    checkOutput("t5_after_count", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
